// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
// Entry rd is stored at a fixed maximum width; narrower register addresses are zero-extended.
package fwd_pkg;

  localparam int FWD_MAX_ADDR_W = 8;
  localparam int FWD_SEL_RF     = 0;

  typedef struct packed {
    logic                      valid;
    logic [FWD_MAX_ADDR_W-1:0] rd;
    logic                      wr;
    logic                      ld;
  } sb_entry_t;

  // r0 and non-writing entries never produce a forwardable value.
  function automatic logic entry_match(input sb_entry_t               e,
                                       input logic [FWD_MAX_ADDR_W-1:0] src,
                                       input logic                    used);
    return e.valid & e.wr & (e.rd != '0) & (e.rd == src) & used;
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Combinational priority encoder for one source operand: forward select
// (youngest producer wins) and load-use hazard flag.
module fwd_src_select
  import fwd_pkg::*;
#(
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = 2
) (
  input  sb_entry_t [DEPTH-1:0]      i_entries,
  input  logic [FWD_MAX_ADDR_W-1:0]  i_src,
  input  logic                       i_used,
  output logic [SEL_W-1:0]           o_sel,
  output logic                       o_load_hazard
);

  logic [DEPTH-1:0] w_match;

  for (genvar s = 0; s < DEPTH; s++) begin : g_match
    assign w_match[s] = entry_match(i_entries[s], i_src, i_used);
  end

  always_comb begin
    o_sel         = SEL_W'(FWD_SEL_RF);
    o_load_hazard = 1'b0;
    // Last stage is skipped: the register file writes before it is read.
    for (int s = DEPTH - 2; s >= 0; s--) begin
      if (w_match[s]) o_sel = SEL_W'(s + 1);
    end
    for (int s = 0; s < DEPTH; s++) begin
      if (w_match[s] && i_entries[s].ld && ((s + 1) < LOAD_READY_STAGE))
        o_load_hazard = 1'b1;
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding/hazard scoreboard: tracks in-flight destinations from EX onward and
// produces load-use stall plus registered EX forward selects. Optional StallCount under FWD_PERF_CNT_EN.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC          = 2,
  parameter int REG_ADDR_W       = 5,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          IDValid,
  input  logic [REG_ADDR_W-1:0]         IDRd,
  input  logic                          IDRegWrite,
  input  logic                          IDMemRead,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] IDSrc,
  input  logic [NUM_SRC-1:0]            IDSrcUsed,
  input  logic                          Flush,
  output logic                          Stall,
  output logic [NUM_SRC*SEL_W-1:0]      EXFwdSel,
  output logic [DEPTH-1:0]              StageValid
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]                   StallCount
`endif
);

  sb_entry_t [DEPTH-1:0]       r_entries;
  logic [NUM_SRC*SEL_W-1:0]    r_fwd_sel;
  logic [NUM_SRC*SEL_W-1:0]    w_sel;
  logic [NUM_SRC-1:0]          w_hazard;
  logic                        w_load;
  sb_entry_t                   w_id_entry;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_select #(
      .DEPTH            (DEPTH),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SEL_W            (SEL_W)
    ) u_sel (
      .i_entries     (r_entries),
      .i_src         (FWD_MAX_ADDR_W'(IDSrc[i*REG_ADDR_W +: REG_ADDR_W])),
      .i_used        (IDSrcUsed[i]),
      .o_sel         (w_sel[i*SEL_W +: SEL_W]),
      .o_load_hazard (w_hazard[i])
    );
  end

  assign Stall  = IDValid & (|w_hazard);
  assign w_load = IDValid & ~Stall & ~Flush;

  always_comb begin
    w_id_entry       = '0;
    w_id_entry.valid = 1'b1;
    w_id_entry.rd    = FWD_MAX_ADDR_W'(IDRd);
    w_id_entry.wr    = IDRegWrite | IDMemRead;
    w_id_entry.ld    = IDMemRead;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_entries <= '0;
      r_fwd_sel <= '0;
    end else begin
      r_entries[0] <= w_load ? w_id_entry : sb_entry_t'('0);
      for (int s = 1; s < DEPTH; s++) r_entries[s] <= r_entries[s-1];
      r_fwd_sel <= w_load ? w_sel : '0;
    end
  end

  assign EXFwdSel = r_fwd_sel;

  for (genvar s = 0; s < DEPTH; s++) begin : g_occ
    assign StageValid[s] = r_entries[s].valid & r_entries[s].wr;
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] r_stall_count;

  // A flushed stall is not a real lost cycle, so it is not counted.
  always_ff @(posedge Clk) begin
    if (Reset) r_stall_count <= '0;
    else if (Stall && !Flush && (r_stall_count != 32'hFFFF_FFFF))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign StallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with hand-computed expectations.
module tb_fwd_hazard_scoreboard;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       IDValid;
  logic [4:0] IDRd;
  logic       IDRegWrite;
  logic       IDMemRead;
  logic [9:0] IDSrc;
  logic [1:0] IDSrcUsed;
  logic       Flush;
  logic       Stall;
  logic [3:0] EXFwdSel;
  logic [2:0] StageValid;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] StallCount;
`endif

  int n_total = 0;
  int n_bad   = 0;

  fwd_hazard_scoreboard dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .IDValid    (IDValid),
    .IDRd       (IDRd),
    .IDRegWrite (IDRegWrite),
    .IDMemRead  (IDMemRead),
    .IDSrc      (IDSrc),
    .IDSrcUsed  (IDSrcUsed),
    .Flush      (Flush),
    .Stall      (Stall),
    .EXFwdSel   (EXFwdSel),
    .StageValid (StageValid)
`ifdef FWD_PERF_CNT_EN
    ,
    .StallCount (StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
    IDValid    = v;
    IDRd       = rd;
    IDRegWrite = rw;
    IDMemRead  = mr;
    IDSrc      = {s1, s0};
    IDSrcUsed  = used;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    Flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    tick();
    check_eq("rst_stage_valid", 32'(StageValid), 32'd0);
    check_eq("rst_fwd_sel", 32'(EXFwdSel), 32'd0);
    check_eq("rst_stall", 32'(Stall), 32'd0);
    Reset = 1'b0;

    // back-to-back ALU dependency
    set_id(1, 3, 1, 0, 1, 2, 2'b11);
    check_eq("add_stall", 32'(Stall), 32'd0);
    tick();
    check_eq("add_fwd_sel", 32'(EXFwdSel), 32'd0);
    set_id(1, 4, 1, 0, 3, 5, 2'b11);
    check_eq("sub_stall", 32'(Stall), 32'd0);
    tick();
    check_eq("sub_fwd_sel", 32'(EXFwdSel), 32'h1);
    check_eq("sub_stage_valid", 32'(StageValid), 32'h3);

    // distance 2 -> select WB stage on rt
    set_id(1, 10, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 11, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 12, 1, 0, 1, 10, 2'b11);
    tick();
    check_eq("dist2_fwd_sel", 32'(EXFwdSel), 32'h8);

    // distance 3 -> register file
    set_id(1, 13, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 20, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 21, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 14, 1, 0, 2, 13, 2'b11);
    tick();
    check_eq("dist3_fwd_sel", 32'(EXFwdSel), 32'h0);

    // load-use
    set_id(1, 8, 1, 1, 1, 0, 2'b01);
    tick();
    set_id(1, 9, 1, 0, 8, 8, 2'b11);
    check_eq("lu_stall", 32'(Stall), 32'd1);
    tick();
    check_eq("lu_bubble_sel", 32'(EXFwdSel), 32'd0);
    check_eq("lu_bubble_sv0", 32'(StageValid[0]), 32'd0);
    check_eq("lu_stall_cleared", 32'(Stall), 32'd0);
    tick();
    check_eq("lu_fwd_sel", 32'(EXFwdSel), 32'hA);
`ifdef FWD_PERF_CNT_EN
    check_eq("lu_stall_count", StallCount, 32'd1);
`endif

    // two writers to r6: youngest wins
    set_id(1, 6, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 6, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 6, 0, 2'b01);
    check_eq("r6_stall", 32'(Stall), 32'd0);
    tick();
    check_eq("r6_fwd_sel", 32'(EXFwdSel), 32'h1);

    // loads to r0 never match
    set_id(1, 0, 1, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 1, 1, 0, 0, 2'b00);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 2'b11);
    check_eq("r0_stall", 32'(Stall), 32'd0);
    tick();
    check_eq("r0_fwd_sel", 32'(EXFwdSel), 32'h0);

    // flush during load-use stall
    set_id(1, 7, 1, 1, 0, 0, 2'b00);
    tick();
    set_id(0, 15, 1, 0, 7, 0, 2'b01);
    check_eq("noid_stall", 32'(Stall), 32'd0);
    Flush = 1'b1;
    set_id(1, 15, 1, 0, 7, 0, 2'b01);
    check_eq("flush_stall", 32'(Stall), 32'd1);
    tick();
    check_eq("flush_fwd_sel", 32'(EXFwdSel), 32'd0);
    check_eq("flush_sv0", 32'(StageValid[0]), 32'd0);
`ifdef FWD_PERF_CNT_EN
    check_eq("flush_stall_count", StallCount, 32'd1);
`endif
    Flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    tick();
    tick();

    // fill pipeline, then reset during a stall
    set_id(1, 1, 1, 0, 0, 0, 2'b00);
    tick();
    set_id(1, 2, 1, 0, 1, 0, 2'b01);
    tick();
    check_eq("fill_fwd_sel_a", 32'(EXFwdSel), 32'h1);
    set_id(1, 3, 1, 1, 2, 0, 2'b01);
    tick();
    check_eq("fill_fwd_sel_b", 32'(EXFwdSel), 32'h1);
    check_eq("fill_stage_valid", 32'(StageValid), 32'h7);
    set_id(1, 5, 1, 0, 3, 0, 2'b01);
    check_eq("fill_stall", 32'(Stall), 32'd1);
    Reset = 1'b1;
    tick();
    check_eq("midrst_stage_valid", 32'(StageValid), 32'd0);
    check_eq("midrst_fwd_sel", 32'(EXFwdSel), 32'd0);
    check_eq("midrst_stall", 32'(Stall), 32'd0);
`ifdef FWD_PERF_CNT_EN
    check_eq("midrst_stall_count", StallCount, 32'd0);
`endif
    Reset = 1'b0;
    tick();
    check_eq("post_rst_fwd_sel", 32'(EXFwdSel), 32'd0);
    check_eq("post_rst_stage_valid", 32'(StageValid), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
